// File: rtl/fft_frame_packetizer.sv
// Frames the ADC sample stream into FFT_LEN-word Avalon-ST packets for the FFT
// input FIFO, with optional pair summing, an elastic buffer and a sticky drop flag.
module fft_frame_packetizer #(
    parameter int ADC_W     = 14,
    parameter int DATA_W    = 15,
    parameter int FFT_LEN   = 1024,
    parameter int BUF_DEPTH = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              adc_valid,
    input  logic              start,
    input  logic              abort,
    input  logic              sum2,
    input  logic [15:0]       num_frames,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int BEAT_W = $clog2(FFT_LEN);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic              sum2_r;
    logic [15:0]       frames_r;
    logic [31:0]       target;
    logic [31:0]       cap_cnt;
    logic [ADC_W-1:0]  s_cur;
    logic [ADC_W-1:0]  even_r;
    logic              phase;
    logic [DATA_W-1:0] conv_data;
    logic              conv_valid;

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [BEAT_W-1:0] beat;

    logic start_ok;
    logic full;
    logic rd_en;
    logic wr_try;
    logic wr_en;
    logic last_write;

    // Offset-binary to two's complement is just an MSB inversion.
    assign s_cur  = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};
    assign target = {16'd0, frames_r} << BEAT_W;

    assign start_ok   = start & ~abort & ((state == IDLE) | (state == DONE));
    assign full       = (count == CNT_W'(BUF_DEPTH));
    assign out_valid  = (count != '0);
    assign rd_en      = out_valid & out_ready;
    assign wr_try     = conv_valid & (state == STREAM) & ~abort;
    // A full buffer still accepts a word when its head leaves in the same cycle.
    assign wr_en      = wr_try & (~full | rd_en);
    assign last_write = wr_en & ((cap_cnt + 32'd1) == target);

    // Gating with out_valid keeps the bus at zero out of reset and between packets.
    assign out_data          = out_valid ? mem[rd_ptr] : '0;
    assign out_startofpacket = out_valid & (beat == '0);
    assign out_endofpacket   = out_valid & (beat == BEAT_W'(FFT_LEN - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (abort)          state_nxt = IDLE;
                else if (start)     state_nxt = (num_frames == 16'd0) ? DONE : STREAM;
            end
            STREAM: begin
                if (abort)          state_nxt = IDLE;
                else if (last_write) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort)          state_nxt = IDLE;
                else if (!out_valid && beat == '0) state_nxt = DONE;
            end
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            STREAM, DRAIN: busy = 1'b1;
            DONE:          done = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sum2_r     <= 1'b0;
            frames_r   <= '0;
            cap_cnt    <= '0;
            even_r     <= '0;
            phase      <= 1'b0;
            conv_data  <= '0;
            conv_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat       <= '0;
            overflow   <= 1'b0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat       <= '0;
            conv_valid <= 1'b0;
            phase      <= 1'b0;
        end else if (start_ok) begin
            sum2_r     <= sum2;
            frames_r   <= num_frames;
            overflow   <= 1'b0;
            cap_cnt    <= '0;
            beat       <= '0;
            phase      <= 1'b0;
            conv_valid <= 1'b0;
        end else begin
            if (state == STREAM && adc_valid) begin
                if (!sum2_r) begin
                    conv_data  <= {s_cur[ADC_W-1], s_cur};
                    conv_valid <= 1'b1;
                end else if (!phase) begin
                    even_r     <= s_cur;
                    phase      <= 1'b1;
                    conv_valid <= 1'b0;
                end else begin
                    conv_data  <= {even_r[ADC_W-1], even_r} + {s_cur[ADC_W-1], s_cur};
                    phase      <= 1'b0;
                    conv_valid <= 1'b1;
                end
            end else begin
                conv_valid <= 1'b0;
            end

            if (wr_en) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                cap_cnt <= cap_cnt + 32'd1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                beat   <= beat + BEAT_W'(1);
            end
            count <= count + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, rd_en};

            if (wr_try && !wr_en) overflow <= 1'b1;
        end
    end

    // NOTE: buffer storage has no reset; occupancy is tracked by count, and
    // leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk_clk) begin
        if (wr_en) mem[wr_ptr] <= conv_data;
    end

endmodule

// File: tb/tb_fft_frame_packetizer.sv
// Randomized bench for fft_frame_packetizer; expected words come from an
// arithmetic model of the sample stream (value - 2^(ADC_W-1), optionally paired).
module tb_fft_frame_packetizer;

    localparam int ADC_W     = 14;
    localparam int DATA_W    = 15;
    localparam int FFT_LEN   = 8;
    localparam int BUF_DEPTH = 8;
    localparam int OFFSET    = 1 << (ADC_W - 1);

    logic              clk_clk = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic [ADC_W-1:0]  adc_data = '0;
    logic              adc_valid = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              sum2 = 1'b0;
    logic [15:0]       num_frames = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_startofpacket;
    logic              out_endofpacket;
    logic              busy;
    logic              done;
    logic              overflow;

    fft_frame_packetizer #(
        .ADC_W(ADC_W), .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .start(start), .abort(abort), .sum2(sum2), .num_frames(num_frames),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } word_t;

    word_t            got[$];
    logic [ADC_W-1:0] samples[$];
    logic [ADC_W-1:0] preset[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects handshaken words and checks hold-while-stalled.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic              prev_sop, prev_eop;
    always @(negedge clk_clk) begin
        if (!reset_reset_n || abort) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_sop", out_startofpacket, prev_sop);
                check("stall_eop", out_endofpacket, prev_eop);
            end
            if (out_valid && out_ready)
                got.push_back('{data: out_data, sop: out_startofpacket, eop: out_endofpacket});
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_sop   = out_startofpacket;
            prev_eop   = out_endofpacket;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] to_word(input int v);
        logic [31:0] t;
        t = v;
        return t[DATA_W-1:0];
    endfunction

    task automatic step(input bit v, input bit r);
        adc_valid = v;
        adc_data  = ADC_W'($urandom);
        out_ready = r;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic verify(input int frames, input bit s2, input bit exact);
        logic [DATA_W-1:0] exp_q[$];
        int j;
        if (!s2) begin
            foreach (samples[i]) exp_q.push_back(to_word(int'(samples[i]) - OFFSET));
        end else begin
            for (int i = 0; i + 1 < samples.size(); i += 2)
                exp_q.push_back(to_word(int'(samples[i]) - OFFSET + int'(samples[i+1]) - OFFSET));
        end
        check("word_count", got.size(), frames * FFT_LEN);
        check("model_covers_output", exp_q.size() >= got.size(), 1);
        j = 0;
        foreach (got[i]) begin
            check($sformatf("sop[%0d]", i), got[i].sop, (i % FFT_LEN) == 0);
            check($sformatf("eop[%0d]", i), got[i].eop, (i % FFT_LEN) == FFT_LEN - 1);
            if (exact) begin
                if (i < exp_q.size()) check($sformatf("data[%0d]", i), got[i].data, exp_q[i]);
            end else begin
                while (j < exp_q.size() && exp_q[j] !== got[i].data) j++;
                check($sformatf("data_in_order[%0d]", i), j < exp_q.size(), 1);
                j++;
            end
        end
    endtask

    // mode 0: ready=1; 1: random ready plus an ignored mid-stream start;
    // 2: 20-cycle stall; 3: fill buffer then read+write in the same cycle.
    task automatic run_capture(input int frames, input bit s2, input int mode,
                               input int valid_pct, input bit exact, input int exp_lat);
        int cyc;
        int first_ov;
        got.delete();
        samples.delete();
        start      = 1'b1;
        sum2       = s2;
        num_frames = 16'(frames);
        adc_valid  = 1'b1;
        adc_data   = 14'h3ABC;
        out_ready  = 1'b1;
        @(posedge clk_clk);
        #1;
        start = 1'b0;
        check("start_clears_overflow", overflow, 0);
        check("start_busy", busy, frames != 0);
        check("start_done", done, frames == 0);
        cyc = 0;
        first_ov = -1;
        while (!done && cyc < 600) begin
            if (out_valid && first_ov < 0) first_ov = cyc;
            case (mode)
                1:       out_ready = 1'($urandom_range(1));
                2:       out_ready = !(cyc >= 4 && cyc < 24);
                3:       out_ready = (cyc >= 10);
                default: out_ready = 1'b1;
            endcase
            if (mode == 3) adc_valid = (cyc != 8);
            else           adc_valid = ($urandom_range(99) < valid_pct);
            if (adc_valid && preset.size() > 0) adc_data = preset.pop_front();
            else                                adc_data = ADC_W'($urandom);
            if (adc_valid) samples.push_back(adc_data);
            if (mode == 1 && cyc == 7) begin
                start      = 1'b1;
                num_frames = 16'd5;
                sum2       = ~s2;
            end else begin
                start = 1'b0;
            end
            if (mode == 2 && cyc == 24) check("overflow_after_stall", overflow, 1);
            @(posedge clk_clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("done_reached", done, 1);
        if (exp_lat >= 0) check("first_valid_latency", first_ov, exp_lat);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1);
            check("idle_out_valid", out_valid, 0);
            check("done_held", done, 1);
            check("idle_busy", busy, 0);
        end
        verify(frames, s2, exact);
    endtask

    initial begin
        int n;
        int cyc;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sop", out_startofpacket, 0);
        check("rst_eop", out_endofpacket, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        reset_reset_n = 1'b1;
        step(1'b0, 1'b1);

        // Ramp 0x2000.. pass-through, two frames
        for (int i = 0; i < 16; i++) preset.push_back(ADC_W'(14'h2000 + i));
        run_capture(2, 1'b0, 0, 100, 1'b1, 2);
        if (got.size() == 16) begin
            check("ramp_first", got[0].data, 15'h0000);
            check("ramp_last", got[15].data, 15'h000F);
        end
        check("ramp_overflow", overflow, 0);

        // Pair summing at the extremes
        preset.delete();
        preset.push_back(14'h3FFF); preset.push_back(14'h3FFF);
        preset.push_back(14'h0000); preset.push_back(14'h0000);
        run_capture(1, 1'b1, 0, 100, 1'b1, -1);
        if (got.size() >= 2) begin
            check("sum_max", got[0].data, 15'h3FFE);
            check("sum_min", got[1].data, 15'h4000);
        end
        check("sum_overflow", overflow, 0);

        // Full buffer with simultaneous read and write: no drop
        run_capture(2, 1'b0, 3, 0, 1'b1, -1);
        check("full_rw_overflow", overflow, 0);

        // Random backpressure, random valid, ignored start mid-stream
        run_capture(2, 1'($urandom_range(1)), 1, 60, 1'b0, -1);

        // Long stall: drops, sticky overflow, exact word count
        run_capture(3, 1'b0, 2, 100, 1'b0, -1);
        check("stall_overflow", overflow, 1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
        check("overflow_sticky", overflow, 1);

        // Abort mid frame 2 (with a coincident start, which abort overrides)
        got.delete();
        start = 1'b1; num_frames = 16'd2; sum2 = 1'b0;
        step(1'b1, 1'b1);
        start = 1'b0;
        check("abort_run_ovf_cleared", overflow, 0);
        cyc = 0;
        while (got.size() < 10 && cyc < 100) begin
            step(1'b1, 1'b1);
            cyc++;
        end
        check("abort_reached_frame2", got.size() >= 10, 1);
        abort = 1'b1; start = 1'b1;
        step(1'b1, 1'b1);
        abort = 1'b0; start = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sop", out_startofpacket, 0);
        n = got.size();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
        check("abort_no_output", got.size(), n);
        run_capture(1, 1'b0, 0, 80, 1'b1, -1);

        // Zero frames: immediate DONE, no output
        run_capture(0, 1'b0, 0, 100, 1'b1, -1);

        // Asynchronous reset mid-packet while stalled
        start = 1'b1; num_frames = 16'd2; sum2 = 1'b0;
        step(1'b1, 1'b0);
        start = 1'b0;
        for (int k = 0; k < 15; k++) step(1'b1, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_sop", out_startofpacket, 1);
        check("pre_rst_overflow", overflow, 1);
        check("pre_rst_busy", busy, 1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_sop", out_startofpacket, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_overflow", overflow, 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        reset_reset_n = 1'b1;
        step(1'b0, 1'b1);
        run_capture(1, 1'b0, 0, 100, 1'b1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
